// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags,
// same-cycle commit bypass, flush and registered commit broadcast.
module rename_register_file #(
  parameter int NUM_REGS = 32,
  parameter int REG_ID_W = 5,
  parameter int ROB_ID_W = 5,
  parameter int XLEN     = 32,
  parameter int NUM_READ = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic                         launch_valid,
  input  logic [ROB_ID_W-1:0]          launch_rob_id,
  input  logic [REG_ID_W-1:0]          launch_reg_id,
  input  logic                         commit_valid,
  input  logic [ROB_ID_W-1:0]          commit_rob_id,
  input  logic [REG_ID_W-1:0]          commit_reg_id,
  input  logic [XLEN-1:0]              commit_value,
  input  logic [NUM_READ*REG_ID_W-1:0] rd_reg_id,
  output logic [NUM_READ-1:0]          rd_has_dep,
  output logic [NUM_READ*ROB_ID_W-1:0] rd_dep_rob_id,
  output logic [NUM_READ*XLEN-1:0]     rd_value,
  output logic                         bcast_valid,
  output logic [ROB_ID_W-1:0]          bcast_rob_id,
  output logic [XLEN-1:0]              bcast_value,
  output logic [REG_ID_W:0]            busy_count
);

  localparam int CNT_W = REG_ID_W + 1;

  logic [XLEN-1:0]     r_value [NUM_REGS];
  logic [ROB_ID_W-1:0] r_tag   [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  logic [ROB_ID_W-1:0] w_tag_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_commit;

  assign w_commit = commit_valid && rdy_in;

  // Launch is applied after the clear so a same-cycle launch wins busy/tag.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_tag_nxt[i] = r_tag[i];
    end
    if (flush_in) begin
      w_busy_nxt = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        w_tag_nxt[i] = '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (commit_valid &&
            commit_reg_id == REG_ID_W'(i) &&
            r_busy[i] &&
            r_tag[i] == commit_rob_id) begin
          w_busy_nxt[i] = 1'b0;
        end
        if (launch_valid &&
            launch_reg_id == REG_ID_W'(i)) begin
          w_busy_nxt[i] = 1'b1;
          w_tag_nxt[i]  = launch_rob_id;
        end
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + CNT_W'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_busy       <= '0;
      busy_count   <= '0;
      bcast_valid  <= 1'b0;
      bcast_rob_id <= '0;
      bcast_value  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_value[i] <= '0;
        r_tag[i]   <= '0;
      end
    end else if (rdy_in) begin
      r_busy     <= w_busy_nxt;
      busy_count <= w_cnt_nxt;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_tag[i] <= w_tag_nxt[i];
      end
      for (int i = 1; i < NUM_REGS; i++) begin
        if (commit_valid &&
            commit_reg_id == REG_ID_W'(i)) begin
          r_value[i] <= commit_value;
        end
      end
      // Reg-0 commits are still broadcast; the RS may wait on them.
      bcast_valid <= commit_valid;
      if (commit_valid) begin
        bcast_rob_id <= commit_rob_id;
        bcast_value  <= commit_value;
      end
    end
  end

  always_comb begin : p_read
    logic [REG_ID_W-1:0] v_r;
    logic                v_busy;
    logic [ROB_ID_W-1:0] v_tag;
    logic [XLEN-1:0]     v_val;
    rd_has_dep    = '0;
    rd_dep_rob_id = '0;
    rd_value      = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      v_r    = rd_reg_id[k*REG_ID_W +: REG_ID_W];
      v_busy = 1'b0;
      v_tag  = '0;
      v_val  = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (v_r == REG_ID_W'(i)) begin
          v_busy = r_busy[i];
          v_tag  = r_tag[i];
          v_val  = r_value[i];
        end
      end
      if (v_busy && w_commit &&
          commit_rob_id == v_tag) begin
        rd_value[k*XLEN +: XLEN] = commit_value;
      end else if (v_busy) begin
        rd_has_dep[k] = 1'b1;
        rd_dep_rob_id[k*ROB_ID_W +: ROB_ID_W] = v_tag;
      end else begin
        rd_value[k*XLEN +: XLEN] = v_val;
      end
    end
  end

endmodule

// File: tb/tb_rename_register_file.sv
// Directed bench for rename_register_file: rename, bypass,
// commit ordering, flush, stall and register-0 handling.
module tb_rename_register_file;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        l_valid;
  logic [4:0]  l_rob;
  logic [4:0]  l_reg;
  logic        c_valid;
  logic [4:0]  c_rob;
  logic [4:0]  c_reg;
  logic [31:0] c_val;
  logic [9:0]  rd_reg;
  logic [1:0]  has_dep;
  logic [9:0]  dep_rob;
  logic [63:0] rd_val;
  logic        b_valid;
  logic [4:0]  b_rob;
  logic [31:0] b_val;
  logic [5:0]  bcnt;

  int n_pass;
  int n_total;

  rename_register_file dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .rdy_in        (rdy),
    .flush_in      (flush),
    .launch_valid  (l_valid),
    .launch_rob_id (l_rob),
    .launch_reg_id (l_reg),
    .commit_valid  (c_valid),
    .commit_rob_id (c_rob),
    .commit_reg_id (c_reg),
    .commit_value  (c_val),
    .rd_reg_id     (rd_reg),
    .rd_has_dep    (has_dep),
    .rd_dep_rob_id (dep_rob),
    .rd_value      (rd_val),
    .bcast_valid   (b_valid),
    .bcast_rob_id  (b_rob),
    .bcast_value   (b_val),
    .busy_count    (bcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush   = 1'b0;
    l_valid = 1'b0;
    l_rob   = '0;
    l_reg   = '0;
    c_valid = 1'b0;
    c_rob   = '0;
    c_reg   = '0;
    c_val   = '0;
  endtask

  task automatic set_rd(input logic [4:0] p1, input logic [4:0] p0);
    rd_reg = {p1, p0};
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    rd_reg = '0;
    tick();
    tick();
    rst = 1'b0;
    set_rd(5'd0, 5'd5);
    n_total++;
    if (has_dep !== 2'b00)
      $display("FAIL t1_has_dep got %b want 00", has_dep);
    else n_pass++;
    n_total++;
    if (rd_val !== 64'd0)
      $display("FAIL t1_values got %h want 0", rd_val);
    else n_pass++;
    n_total++;
    if (dep_rob !== 10'd0)
      $display("FAIL t1_dep_rob got %h want 0", dep_rob);
    else n_pass++;
    n_total++;
    if (bcnt !== 6'd0)
      $display("FAIL t1_busy_count got %0d want 0", bcnt);
    else n_pass++;
    n_total++;
    if (b_valid !== 1'b0)
      $display("FAIL t1_bcast_valid got %b want 0", b_valid);
    else n_pass++;
  endtask

  task automatic test_bypass();
    l_valid = 1'b1; l_rob = 5'd7; l_reg = 5'd3;
    tick();
    idle();
    set_rd(5'd0, 5'd3);
    n_total++;
    if (has_dep[0] !== 1'b1 || dep_rob[4:0] !== 5'd7)
      $display("FAIL t2_dep got %b/%0d want 1/7", has_dep[0], dep_rob[4:0]);
    else n_pass++;
    n_total++;
    if (bcnt !== 6'd1)
      $display("FAIL t2_count_up got %0d want 1", bcnt);
    else n_pass++;
    c_valid = 1'b1; c_rob = 5'd7; c_reg = 5'd3; c_val = 32'hDEADBEEF;
    #2;
    n_total++;
    if (has_dep[0] !== 1'b0 || rd_val[31:0] !== 32'hDEADBEEF)
      $display("FAIL t2_bypass got %b/%h want 0/deadbeef", has_dep[0], rd_val[31:0]);
    else n_pass++;
    tick();
    idle();
    #2;
    n_total++;
    if (has_dep[0] !== 1'b0 || rd_val[31:0] !== 32'hDEADBEEF)
      $display("FAIL t2_after got %b/%h want 0/deadbeef", has_dep[0], rd_val[31:0]);
    else n_pass++;
    n_total++;
    if (bcnt !== 6'd0)
      $display("FAIL t2_count_down got %0d want 0", bcnt);
    else n_pass++;
    n_total++;
    if (b_valid !== 1'b1 || b_rob !== 5'd7 || b_val !== 32'hDEADBEEF)
      $display("FAIL t2_bcast got %b/%0d/%h want 1/7/deadbeef", b_valid, b_rob, b_val);
    else n_pass++;
  endtask

  task automatic test_younger_survives();
    l_valid = 1'b1; l_rob = 5'd2; l_reg = 5'd4;
    tick();
    l_rob = 5'd9;
    tick();
    idle();
    c_valid = 1'b1; c_rob = 5'd2; c_reg = 5'd4; c_val = 32'h11;
    set_rd(5'd4, 5'd3);
    n_total++;
    if (has_dep[1] !== 1'b1 || dep_rob[9:5] !== 5'd9)
      $display("FAIL t3_no_bypass got %b/%0d want 1/9", has_dep[1], dep_rob[9:5]);
    else n_pass++;
    tick();
    idle();
    #2;
    n_total++;
    if (has_dep[1] !== 1'b1 || dep_rob[9:5] !== 5'd9)
      $display("FAIL t3_dep got %b/%0d want 1/9", has_dep[1], dep_rob[9:5]);
    else n_pass++;
    n_total++;
    if (bcnt !== 6'd1)
      $display("FAIL t3_count got %0d want 1", bcnt);
    else n_pass++;
    n_total++;
    if (b_valid !== 1'b1 || b_rob !== 5'd2)
      $display("FAIL t3_bcast got %b/%0d want 1/2", b_valid, b_rob);
    else n_pass++;
    flush = 1'b1;
    tick();
    idle();
    #2;
    n_total++;
    if (has_dep[1] !== 1'b0 || rd_val[63:32] !== 32'h11)
      $display("FAIL t3_value got %b/%h want 0/11", has_dep[1], rd_val[63:32]);
    else n_pass++;
  endtask

  task automatic test_launch_commit_same();
    l_valid = 1'b1; l_rob = 5'd4; l_reg = 5'd6;
    c_valid = 1'b1; c_rob = 5'd1; c_reg = 5'd6; c_val = 32'h66;
    tick();
    idle();
    set_rd(5'd0, 5'd6);
    n_total++;
    if (has_dep[0] !== 1'b1 || dep_rob[4:0] !== 5'd4)
      $display("FAIL t4_dep got %b/%0d want 1/4", has_dep[0], dep_rob[4:0]);
    else n_pass++;
    n_total++;
    if (bcnt !== 6'd1)
      $display("FAIL t4_count got %0d want 1", bcnt);
    else n_pass++;
    flush = 1'b1;
    tick();
    idle();
    #2;
    n_total++;
    if (has_dep[0] !== 1'b0 || rd_val[31:0] !== 32'h66)
      $display("FAIL t4_value got %b/%h want 0/66", has_dep[0], rd_val[31:0]);
    else n_pass++;
  endtask

  task automatic test_flush();
    l_valid = 1'b1; l_rob = 5'd10; l_reg = 5'd1;
    tick();
    l_rob = 5'd11; l_reg = 5'd2;
    tick();
    l_rob = 5'd12; l_reg = 5'd3;
    tick();
    idle();
    #2;
    n_total++;
    if (bcnt !== 6'd3)
      $display("FAIL t5_count3 got %0d want 3", bcnt);
    else n_pass++;
    flush = 1'b1;
    c_valid = 1'b1; c_rob = 5'd5; c_reg = 5'd8; c_val = 32'h42;
    l_valid = 1'b1; l_rob = 5'd13; l_reg = 5'd9;
    tick();
    idle();
    set_rd(5'd9, 5'd8);
    n_total++;
    if (bcnt !== 6'd0)
      $display("FAIL t5_count0 got %0d want 0", bcnt);
    else n_pass++;
    n_total++;
    if (has_dep !== 2'b00 || rd_val !== {32'h0, 32'h42})
      $display("FAIL t5_reads got %b/%h want 00/%h", has_dep, rd_val, {32'h0, 32'h42});
    else n_pass++;
    n_total++;
    if (b_valid !== 1'b1 || b_rob !== 5'd5 || b_val !== 32'h42)
      $display("FAIL t5_bcast got %b/%0d/%h want 1/5/42", b_valid, b_rob, b_val);
    else n_pass++;
    set_rd(5'd2, 5'd1);
    n_total++;
    if (has_dep !== 2'b00)
      $display("FAIL t5_cleared got %b want 00", has_dep);
    else n_pass++;
  endtask

  task automatic test_stall_and_r0();
    l_valid = 1'b1; l_rob = 5'd3; l_reg = 5'd10;
    c_valid = 1'b1; c_rob = 5'd20; c_reg = 5'd11; c_val = 32'h77;
    tick();
    rdy = 1'b0;
    flush = 1'b1;
    l_valid = 1'b1; l_rob = 5'd14; l_reg = 5'd12;
    c_valid = 1'b1; c_rob = 5'd3; c_reg = 5'd10; c_val = 32'h99;
    tick();
    tick();
    set_rd(5'd12, 5'd10);
    n_total++;
    if (bcnt !== 6'd1)
      $display("FAIL t6_count got %0d want 1", bcnt);
    else n_pass++;
    n_total++;
    if (b_valid !== 1'b1 || b_rob !== 5'd20 || b_val !== 32'h77)
      $display("FAIL t6_bcast_held got %b/%0d/%h want 1/20/77", b_valid, b_rob, b_val);
    else n_pass++;
    n_total++;
    if (has_dep !== 2'b01 || dep_rob[4:0] !== 5'd3)
      $display("FAIL t6_reads got %b/%0d want 01/3", has_dep, dep_rob[4:0]);
    else n_pass++;
    set_rd(5'd11, 5'd10);
    n_total++;
    if (has_dep[1] !== 1'b0 || rd_val[63:32] !== 32'h77)
      $display("FAIL t6_r11 got %b/%h want 0/77", has_dep[1], rd_val[63:32]);
    else n_pass++;
    rdy = 1'b1;
    idle();
    tick();
    #2;
    n_total++;
    if (b_valid !== 1'b0 || b_rob !== 5'd20)
      $display("FAIL t6_bcast_drop got %b/%0d want 0/20", b_valid, b_rob);
    else n_pass++;
    l_valid = 1'b1; l_rob = 5'd15; l_reg = 5'd0;
    c_valid = 1'b1; c_rob = 5'd16; c_reg = 5'd0; c_val = 32'h5;
    tick();
    idle();
    set_rd(5'd0, 5'd0);
    n_total++;
    if (has_dep !== 2'b00 || rd_val !== 64'd0)
      $display("FAIL t6_r0 got %b/%h want 00/0", has_dep, rd_val);
    else n_pass++;
    n_total++;
    if (bcnt !== 6'd1)
      $display("FAIL t6_r0_count got %0d want 1", bcnt);
    else n_pass++;
    n_total++;
    if (b_valid !== 1'b1 || b_rob !== 5'd16 || b_val !== 32'h5)
      $display("FAIL t6_r0_bcast got %b/%0d/%h want 1/16/5", b_valid, b_rob, b_val);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_bypass();
    test_younger_survives();
    test_launch_commit_same();
    test_flush();
    test_stall_and_r0();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
